// File: rtl/dmem_line_responder_pkg.sv
// Shared types for the dmem line responder: FSM states,
// line geometry, request bundle and the byte-merge helper.
package dmem_line_responder_pkg;

  localparam int LINE_BYTES = 32;
  localparam int BEAT_BITS  = 64;
  localparam int BEATS      = 4;
  localparam int TAG_W      = 27;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    MERGE,
    FLUSH,
    RESP
  } dmem_rsp_state_t;

  typedef logic [BEAT_BITS-1:0] beat_t;
  typedef logic [TAG_W-1:0]     tag_t;

  // Request/response bundle for the word-granular dmem side.
  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } dmem_t;

  function automatic logic [31:0] merge_word(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [3:0]  wmask
  );
    logic [31:0] w;
    w = old;
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) w[8*i +: 8] = wdata[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_line_buffer.sv
// One-entry 256-bit line buffer: tag/valid, beat fill, byte-masked
// word merge, beat and word read ports.
// Ports: clk, rst_n; tag/beat_sel/half_sel lookup address;
// fill_en/fill_last/fill_idx/fill_data beat write; merge_en/wmask/wdata
// word merge; rd_idx -> rd_beat; hit, rd_word for the selected word.
module dmem_line_buffer
  import dmem_line_responder_pkg::*;
#(
  parameter bit LINE_BUF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [26:0] tag,
  input  logic [1:0]  beat_sel,
  input  logic        half_sel,
  input  logic        fill_en,
  input  logic        fill_last,
  input  logic [1:0]  fill_idx,
  input  logic [63:0] fill_data,
  input  logic        merge_en,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  input  logic [1:0]  rd_idx,
  output logic        hit,
  output logic [63:0] rd_beat,
  output logic [31:0] rd_word
);

  logic [BEATS-1:0][BEAT_BITS-1:0] line_q;
  logic [BEATS-1:0][BEAT_BITS-1:0] view;
  logic [BEAT_BITS-1:0] sel;
  logic [31:0] merged;
  tag_t tag_q;
  logic valid_q;

  // view is the line as it will be after this edge, so the
  // last fill beat and the merged word are readable at once.
  always_comb begin
    view = line_q;
    if (fill_en) view[fill_idx] = fill_data;
    sel = view[beat_sel];
    rd_word = half_sel ? sel[63:32] : sel[31:0];
    merged = merge_word(rd_word, wdata, wmask);
    if (merge_en) begin
      if (half_sel) view[beat_sel][63:32] = merged;
      else view[beat_sel][31:0] = merged;
    end
  end

  assign rd_beat = view[rd_idx];
  assign hit = LINE_BUF_EN && valid_q && (tag_q == tag);

  always_ff @(posedge clk) begin
    if (fill_en || merge_en) line_q <= view;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else if (fill_last) begin
      valid_q <= LINE_BUF_EN;
      tag_q   <= tag;
    end
  end

endmodule

// File: rtl/dmem_line_responder.sv
// Answers word dmem requests from a 4x64-bit line burst port;
// stores are read-modify-write, written through, one line cached.
// Ports: clk, rst_n; dmem_address/read/write/rmask/wmask/wdata in,
// dmem_rdata/dmem_resp out; pmem_address/read/write/wdata out,
// pmem_rdata/pmem_resp in.
module dmem_line_responder #(
  parameter bit LINE_BUF_EN = 1'b1,
  parameter int BEATS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_address,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [63:0] pmem_wdata,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);

  import dmem_line_responder_pkg::*;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  dmem_rsp_state_t state;
  logic [1:0] cnt;
  logic req;
  logic is_wr;
  logic no_bytes;
  logic hit;
  logic fill_en;
  logic fill_last;
  logic merge_en;
  logic [1:0] rd_idx;
  logic [63:0] rd_beat;
  logic [31:0] rd_word;
  logic unused_ok;

  // Read+write together is a write.
  assign req = dmem_read | dmem_write;
  assign is_wr = dmem_write;
  assign no_bytes = dmem_wmask == 4'b0;

  assign fill_en = (state == FILL) && pmem_resp;
  assign fill_last = fill_en && (cnt == LAST_BEAT);
  assign merge_en = state == MERGE;
  // Flush preloads the beat after the one being accepted.
  assign rd_idx = (state == FLUSH) ? cnt + 2'd1 : 2'd0;

  assign unused_ok = ^{dmem_rmask, dmem_address[1:0]};

  dmem_line_buffer #(
    .LINE_BUF_EN(LINE_BUF_EN)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .tag      (dmem_address[31:5]),
    .beat_sel (dmem_address[4:3]),
    .half_sel (dmem_address[2]),
    .fill_en  (fill_en),
    .fill_last(fill_last),
    .fill_idx (cnt),
    .fill_data(pmem_rdata),
    .merge_en (merge_en),
    .wmask    (dmem_wmask),
    .wdata    (dmem_wdata),
    .rd_idx   (rd_idx),
    .hit      (hit),
    .rd_beat  (rd_beat),
    .rd_word  (rd_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      dmem_resp    <= 1'b0;
      dmem_rdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      dmem_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            pmem_address <= {dmem_address[31:5], 5'b0};
            cnt <= '0;
            if (is_wr && no_bytes) begin
              state     <= RESP;
              dmem_resp <= 1'b1;
            end else if (hit) begin
              if (is_wr) begin
                state <= MERGE;
              end else begin
                state      <= RESP;
                dmem_resp  <= 1'b1;
                dmem_rdata <= rd_word;
              end
            end else begin
              state     <= FILL;
              pmem_read <= 1'b1;
            end
          end
        end
        FILL: begin
          if (pmem_resp) begin
            cnt <= cnt + 2'd1;
            if (cnt == LAST_BEAT) begin
              pmem_read <= 1'b0;
              if (is_wr) begin
                state <= MERGE;
              end else begin
                state      <= RESP;
                dmem_resp  <= 1'b1;
                dmem_rdata <= rd_word;
              end
            end
          end
        end
        MERGE: begin
          state      <= FLUSH;
          cnt        <= '0;
          pmem_write <= 1'b1;
          pmem_wdata <= rd_beat;
        end
        FLUSH: begin
          if (pmem_resp) begin
            cnt        <= cnt + 2'd1;
            pmem_wdata <= rd_beat;
            if (cnt == LAST_BEAT) begin
              pmem_write <= 1'b0;
              state      <= RESP;
              dmem_resp  <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Randomised and directed bench for dmem_line_responder against a
// word-level memory model and a one-line buffer model.
module tb_dmem_line_responder;
  import dmem_line_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] dmem_address = '0;
  logic dmem_read = 1'b0;
  logic dmem_write = 1'b0;
  logic [3:0] dmem_rmask = '0;
  logic [3:0] dmem_wmask = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic dmem_resp;
  logic [31:0] pmem_address;
  logic pmem_read;
  logic pmem_write;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata = '0;
  logic pmem_resp = 1'b0;

  always #5 clk = ~clk;

  dmem_line_responder dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_address(dmem_address), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit stall_en = 1'b0;

  logic [63:0] phys [int];
  logic [31:0] refw [int];
  bit m_valid = 1'b0;
  logic [26:0] m_tag = '0;

  int rd_beats = 0;
  int wr_beats = 0;
  int act_cycles = 0;
  int mbeat = 0;
  int overlap = 0;
  int addr_viol = 0;
  bit prev_act = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] last_addr = '0;
  logic [63:0] wr_log [$];

  function automatic logic [63:0] init_beat(int k);
    return {32'(k) ^ 32'hC3A5_0000, ~32'(k)};
  endfunction

  function automatic logic [63:0] phys_rd(int k);
    if (phys.exists(k)) return phys[k];
    return init_beat(k);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    int w;
    logic [63:0] b;
    w = int'(a >> 2);
    if (refw.exists(w)) return refw[w];
    b = init_beat(w >> 1);
    return w[0] ? b[63:32] : b[31:0];
  endfunction

  function automatic void preload(logic [31:0] a, logic [63:0] d);
    int k;
    k = int'(a >> 3);
    phys[k] = d;
    refw[2*k] = d[31:0];
    refw[2*k+1] = d[63:32];
  endfunction

  function automatic dmem_t mk(logic [31:0] a, bit r, bit w,
                               logic [3:0] m, logic [31:0] d);
    dmem_t q;
    q = '0;
    q.address = a;
    q.read = r;
    q.write = w;
    q.rmask = 4'hF;
    q.wmask = m;
    q.wdata = d;
    return q;
  endfunction

  // Word-level behaviour: what the read returns, how many beats move.
  function automatic void model_step(input dmem_t q,
                                     output logic [31:0] er,
                                     output int enr, output int enw);
    logic [31:0] w;
    bit h;
    er = ref_rd(q.address);
    enr = 0;
    enw = 0;
    if (q.write && q.wmask == 4'b0) return;
    h = m_valid && (m_tag == q.address[31:5]);
    if (!h) begin
      enr = 4;
      m_valid = 1'b1;
      m_tag = q.address[31:5];
    end
    if (q.write) begin
      enw = 4;
      w = er;
      for (int i = 0; i < 4; i++)
        if (q.wmask[i]) w[8*i +: 8] = q.wdata[8*i +: 8];
      refw[int'(q.address >> 2)] = w;
    end
  endfunction

  // Burst memory: consumes beats at the edge, drives the next beat after.
  initial begin
    forever begin
      @(posedge clk);
      if (pmem_read && pmem_write) overlap++;
      if (pmem_read || pmem_write) begin
        act_cycles++;
        if (prev_act && pmem_address != prev_addr) addr_viol++;
      end
      prev_act = pmem_read || pmem_write;
      prev_addr = pmem_address;
      if (pmem_resp && pmem_write) begin
        phys[int'(pmem_address >> 3) + mbeat] = pmem_wdata;
        wr_log.push_back(pmem_wdata);
        wr_beats++;
        last_addr = pmem_address;
      end
      if (pmem_resp && pmem_read) begin
        rd_beats++;
        last_addr = pmem_address;
      end
      if (pmem_resp && (pmem_read || pmem_write)) mbeat = (mbeat + 1) % 4;
      else if (!pmem_read && !pmem_write) mbeat = 0;
      #1;
      if (pmem_read || pmem_write) begin
        pmem_resp = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        pmem_rdata = pmem_read ? phys_rd(int'(pmem_address >> 3) + mbeat) : '0;
      end else begin
        pmem_resp = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
    $fatal(1);
  end

  // Called at edge+1 with the responder idle; returns one cycle after resp.
  task automatic do_access(input dmem_t q, output logic [31:0] rd,
                           output int cyc, output bit ok);
    rd_beats = 0;
    wr_beats = 0;
    act_cycles = 0;
    wr_log.delete();
    dmem_address = q.address;
    dmem_read = q.read;
    dmem_write = q.write;
    dmem_rmask = q.rmask;
    dmem_wmask = q.wmask;
    dmem_wdata = q.wdata;
    ok = 1'b0;
    rd = '0;
    cyc = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dmem_resp) begin
        ok = 1'b1;
        rd = dmem_rdata;
      end
    end
    @(posedge clk);
    #1;
    dmem_read = 1'b0;
    dmem_write = 1'b0;
  endtask

  logic [31:0] rd, er;
  int cyc, enr, enw;
  bit ok;
  dmem_t q;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({dmem_resp, pmem_read, pmem_write} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000", {dmem_resp, pmem_read, pmem_write});
    end
    n_checks++;
    if ({dmem_rdata, pmem_address, pmem_wdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h want 0", dmem_rdata, pmem_address, pmem_wdata);
    end
    rst_n = 1'b1;
    m_valid = 1'b0;
  endtask

  task automatic test_read_miss();
    for (int k = 0; k < 4; k++)
      preload(32'h1000 + 32'(8*k), {32'h1111_1111 * 32'(2*k+1), 32'h1111_1111 * 32'(2*k)});
    q = mk(32'h1004, 1, 0, 4'h0, '0);
    model_step(q, er, enr, enw);
    do_access(q, rd, cyc, ok);
    n_checks++;
    if (!ok || rd !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL read_miss_data: got %h ok=%0d want 11111111", rd, ok);
    end
    n_checks++;
    if (rd_beats != 4 || wr_beats != 0 || last_addr !== 32'h1000) begin
      n_fail++;
      $display("FAIL read_miss_burst: rd=%0d wr=%0d addr=%h want 4 0 1000", rd_beats, wr_beats, last_addr);
    end
    n_checks++;
    if (cyc != 6) begin
      n_fail++;
      $display("FAIL read_miss_latency: got %0d want 6", cyc);
    end
  endtask

  task automatic test_read_hit();
    q = mk(32'h1018, 1, 0, 4'h0, '0);
    model_step(q, er, enr, enw);
    do_access(q, rd, cyc, ok);
    n_checks++;
    if (!ok || rd !== 32'h6666_6666) begin
      n_fail++;
      $display("FAIL read_hit_data: got %h ok=%0d want 66666666", rd, ok);
    end
    n_checks++;
    if (act_cycles != 0 || cyc != 2) begin
      n_fail++;
      $display("FAIL read_hit_timing: pmem_cycles=%0d lat=%0d want 0 2", act_cycles, cyc);
    end
  endtask

  task automatic test_store_miss();
    for (int k = 0; k < 4; k++) preload(32'h2000 + 32'(8*k), 64'h0);
    q = mk(32'h2008, 0, 1, 4'b0010, 32'hAABB_CCDD);
    model_step(q, er, enr, enw);
    do_access(q, rd, cyc, ok);
    n_checks++;
    if (!ok || rd_beats != 4 || wr_log.size() != 4) begin
      n_fail++;
      $display("FAIL store_miss_burst: ok=%0d rd=%0d wr=%0d want 1 4 4", ok, rd_beats, wr_log.size());
    end else begin
      n_checks++;
      if (wr_log[1] !== 64'h0000_0000_0000_CC00) begin
        n_fail++;
        $display("FAIL store_miss_beat1: got %h want 000000000000cc00", wr_log[1]);
      end
      n_checks++;
      if ((wr_log[0] | wr_log[2] | wr_log[3]) !== 64'h0) begin
        n_fail++;
        $display("FAIL store_miss_other: got %h %h %h want 0", wr_log[0], wr_log[2], wr_log[3]);
      end
    end
  endtask

  task automatic test_store_wmask0();
    q = mk(32'h3000, 0, 1, 4'b0000, 32'h1234_5678);
    model_step(q, er, enr, enw);
    do_access(q, rd, cyc, ok);
    n_checks++;
    if (!ok || cyc != 2 || act_cycles != 0) begin
      n_fail++;
      $display("FAIL store_wmask0: ok=%0d lat=%0d pmem_cycles=%0d want 1 2 0", ok, cyc, act_cycles);
    end
  endtask

  task automatic test_write_hit();
    q = mk(32'h2014, 0, 1, 4'b1001, 32'h1234_5678);
    model_step(q, er, enr, enw);
    do_access(q, rd, cyc, ok);
    n_checks++;
    if (!ok || cyc != 7 || rd_beats != 0 || wr_log.size() != 4) begin
      n_fail++;
      $display("FAIL write_hit_timing: ok=%0d lat=%0d rd=%0d wr=%0d want 1 7 0 4", ok, cyc, rd_beats, wr_log.size());
    end else begin
      n_checks++;
      if (wr_log[2] !== 64'h1200_0078_0000_0000 || wr_log[1] !== 64'h0000_CC00) begin
        n_fail++;
        $display("FAIL write_hit_data: got %h %h want 1200007800000000 000000000000cc00", wr_log[2], wr_log[1]);
      end
    end
    q = mk(32'h2014, 1, 0, 4'h0, '0);
    model_step(q, er, enr, enw);
    do_access(q, rd, cyc, ok);
    n_checks++;
    if (!ok || rd !== 32'h1200_0078 || act_cycles != 0) begin
      n_fail++;
      $display("FAIL write_hit_readback: got %h pmem_cycles=%0d want 12000078 0", rd, act_cycles);
    end
  endtask

  task automatic test_tag_replace();
    logic [31:0] addrs [3];
    logic [31:0] a;
    addrs[0] = 32'h1000;
    addrs[1] = 32'h5000;
    addrs[2] = 32'h1000;
    for (int i = 0; i < 3; i++) begin
      a = addrs[i];
      q = mk(a, 1, 0, 4'h0, '0);
      model_step(q, er, enr, enw);
      do_access(q, rd, cyc, ok);
      n_checks++;
      if (!ok || rd_beats != 4 || rd !== er) begin
        n_fail++;
        $display("FAIL tag_replace_%0d: ok=%0d beats=%0d data=%h want 1 4 %h", i, ok, rd_beats, rd, er);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    preload(32'h7008, 64'hDEAD_BEEF_CAFE_F00D);
    rd_beats = 0;
    dmem_address = 32'h7008;
    dmem_read = 1'b1;
    dmem_write = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (rd_beats >= 2) seen = 1'b1;
    end
    rst_n = 1'b0;
    dmem_read = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (!seen || pmem_read !== 1'b0 || dmem_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fill_abort: seen=%0d pmem_read=%b resp=%b want 1 0 0", seen, pmem_read, dmem_resp);
    end
    rst_n = 1'b1;
    m_valid = 1'b0;
    q = mk(32'h7008, 1, 0, 4'h0, '0);
    model_step(q, er, enr, enw);
    do_access(q, rd, cyc, ok);
    n_checks++;
    if (!ok || rd_beats != 4 || rd !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL reset_mid_fill_refill: ok=%0d beats=%0d data=%h want 1 4 cafef00d", ok, rd_beats, rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] bases [4];
    logic [31:0] a, base;
    int op;
    bit bad;
    logic [63:0] b;
    bases[0] = 32'h1000;
    bases[1] = 32'h2000;
    bases[2] = 32'h9000;
    bases[3] = 32'hA000;
    stall_en = 1'b1;
    for (int it = 0; it < 80; it++) begin
      base = bases[$urandom_range(0, 3)];
      a = base | (32'($urandom_range(0, 7)) << 2);
      op = $urandom_range(0, 9);
      q = mk(a, op < 5 || op == 9, op >= 5, 4'($urandom_range(0, 15)), $urandom);
      model_step(q, er, enr, enw);
      do_access(q, rd, cyc, ok);
      n_checks++;
      if (!ok || rd_beats != enr || wr_beats != enw) begin
        n_fail++;
        $display("FAIL rand_traffic[%0d] a=%h: ok=%0d rd=%0d wr=%0d want 1 %0d %0d", it, a, ok, rd_beats, wr_beats, enr, enw);
      end
      if (!q.write) begin
        n_checks++;
        if (rd !== er) begin
          n_fail++;
          $display("FAIL rand_rdata[%0d] a=%h: got %h want %h", it, a, rd, er);
        end
      end else begin
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
          b = phys_rd(int'(base >> 3) + k / 2);
          if ((k % 2 == 1 ? b[63:32] : b[31:0]) !== ref_rd(base + 32'(4*k))) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
          n_fail++;
          $display("FAIL rand_memline[%0d] a=%h: memory line differs from model", it, a);
        end
      end
    end
    stall_en = 1'b0;
  endtask

  task automatic test_protocol();
    n_checks++;
    if (overlap != 0 || addr_viol != 0) begin
      n_fail++;
      $display("FAIL pmem_protocol: overlap=%0d addr_changes=%0d want 0 0", overlap, addr_viol);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_store_miss();
    test_store_wmask0();
    test_write_hit();
    test_tag_replace();
    test_reset_mid_fill();
    test_random();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
